single_track_arbiter: RTL and testbench

Arbitrates a single-track line section shared by trains approaching from the east and west ends. It grants the section to one direction at a time and drives the entry signal aspect at each end. It also enforces a clearance hold after the section empties before any new grant. The block sits beside the automatic block-signalling chain, using the same 2-bit aspect encoding, and drives the home signals at each end of the shared section.

---
 rtl/single_track_arbiter.sv | 71 +++++++
 tb/tb_single_track_arbiter.sv | 89 ++++++++
 2 files changed

// File: rtl/single_track_arbiter.sv
// single_track_arbiter: grants a shared single-track section to east or west traffic and drives the entry aspects
module single_track_arbiter #(
  parameter int CLEAR_DELAY = 10,
  parameter int GRANT_TIMEOUT = 50,
  parameter int CNT_W = 8
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       req_e,
  input  logic       req_w,
  input  logic       occ,
  output logic [1:0] sig_e,
  output logic [1:0] sig_w,
  output logic       grant_e,
  output logic       grant_w,
  output logic       busy,
  output logic       timeout,
  output logic       last_dir
);
  typedef enum logic [2:0] {IDLE, ROUTE_E, RUN_E, ROUTE_W, RUN_W, CLEAR} state_t;
  localparam logic [CNT_W-1:0] CLR_END = CNT_W'(CLEAR_DELAY - 1);
  localparam logic [CNT_W-1:0] TMO_END = CNT_W'(GRANT_TIMEOUT - 1);
  state_t state, cur, nxt;
  logic [CNT_W-1:0] cnt;
  logic tmo;
  always_comb cur = (state > CLEAR) ? CLEAR : state;
  // occupancy beats cancel, cancel beats timeout
  always_comb begin
    nxt = cur;
    tmo = 1'b0;
    case (cur)
      IDLE:    nxt = occ ? CLEAR : (req_e && (!req_w || last_dir)) ? ROUTE_E : req_w ? ROUTE_W : IDLE;
      ROUTE_E: begin
        nxt = occ ? RUN_E : (!req_e || cnt == TMO_END) ? IDLE : ROUTE_E;
        tmo = !occ && req_e && cnt == TMO_END;
      end
      ROUTE_W: begin
        nxt = occ ? RUN_W : (!req_w || cnt == TMO_END) ? IDLE : ROUTE_W;
        tmo = !occ && req_w && cnt == TMO_END;
      end
      RUN_E:   nxt = occ ? RUN_E : CLEAR;
      RUN_W:   nxt = occ ? RUN_W : CLEAR;
      default: nxt = (!occ && cnt == CLR_END) ? IDLE : CLEAR;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!clr) begin
      state    <= IDLE;
      cnt      <= '0;
      last_dir <= 1'b1;
      timeout  <= 1'b0;
    end else begin
      state    <= nxt;
      cnt      <= (nxt != state || (nxt == CLEAR && occ)) ? '0 : cnt + CNT_W'(~&cnt);
      last_dir <= (nxt == ROUTE_E) ? 1'b0 : (nxt == ROUTE_W) ? 1'b1 : last_dir;
      timeout  <= tmo;
    end
  end
  always_comb begin
    sig_e   = (cur == ROUTE_E) ? 2'd3 : 2'd0;
    sig_w   = (cur == ROUTE_W) ? 2'd3 : 2'd0;
    grant_e = cur == ROUTE_E || cur == RUN_E;
    grant_w = cur == ROUTE_W || cur == RUN_W;
    busy    = cur != IDLE;
  end
`ifndef SYNTHESIS
  a_grant:  assert property (@(posedge clk) !(grant_e && grant_w));
  a_aspect: assert property (@(posedge clk) sig_e == 2'd0 || sig_w == 2'd0);
  a_occ:    assert property (@(posedge clk) disable iff (!clr) occ |=> (sig_e != 2'd3 && sig_w != 2'd3));
`endif
endmodule

// File: tb/tb_single_track_arbiter.sv
// tb_single_track_arbiter: directed vector table plus a timeout/round-robin sequence
module tb_single_track_arbiter;
  logic clk = 1'b0, clr, req_e, req_w, occ;
  logic [1:0] sig_e, sig_w;
  logic grant_e, grant_w, busy, timeout, last_dir;
  int n_vec = 0, n_err = 0;
  typedef struct packed {
    logic clr, re, rw, occ;
    logic [8:0] exp;
  } vec_t;
  vec_t tbl[$];
  single_track_arbiter #(.CLEAR_DELAY(4), .GRANT_TIMEOUT(8), .CNT_W(8)) dut (
    .clk(clk), .clr(clr), .req_e(req_e), .req_w(req_w), .occ(occ),
    .sig_e(sig_e), .sig_w(sig_w), .grant_e(grant_e), .grant_w(grant_w),
    .busy(busy), .timeout(timeout), .last_dir(last_dir)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic add(input int n, input logic c, input logic re, input logic rw, input logic o,
                     input logic [1:0] se, input logic [1:0] sw, input logic ge, input logic gw,
                     input logic b, input logic t, input logic l);
    for (int i = 0; i < n; i++) tbl.push_back({c, re, rw, o, se, sw, ge, gw, b, t, l});
  endtask
  initial begin
    int g;
    bit seen;
    clr = 1'b0; req_e = 1'b0; req_w = 1'b0; occ = 1'b0;
    //   n clr re rw occ | se sw ge gw busy to ld
    add(2, 0, 1, 1, 0,   0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 1, 0,   3, 0, 1, 0, 1, 0, 0);
    add(5, 1, 0, 1, 1,   0, 0, 1, 0, 1, 0, 0);
    add(4, 1, 0, 1, 0,   0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(8, 1, 0, 1, 0,   0, 3, 0, 1, 1, 0, 1);
    add(1, 1, 0, 1, 0,   0, 0, 0, 0, 0, 1, 1);
    add(1, 1, 0, 1, 0,   0, 3, 0, 1, 1, 0, 1);
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 1, 0, 0,   3, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    add(3, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0);
    add(3, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,   3, 0, 1, 0, 1, 0, 0);
    add(1, 1, 0, 0, 1,   0, 0, 1, 0, 1, 0, 0);
    add(1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1);
    add(1, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 1);
    add(1, 1, 0, 0, 0,   0, 0, 0, 0, 1, 0, 1);
    #1;
    foreach (tbl[i]) begin
      clr = tbl[i].clr; req_e = tbl[i].re; req_w = tbl[i].rw; occ = tbl[i].occ;
      tick();
      chk($sformatf("vec%0d {se,sw,ge,gw,busy,to,ld}", i),
          int'({sig_e, sig_w, grant_e, grant_w, busy, timeout, last_dir}), int'(tbl[i].exp));
    end
    clr = 1'b0; req_e = 1'b0; req_w = 1'b1; occ = 1'b0;
    tick();
    clr = 1'b1;
    tick();
    g = int'(grant_w);
    req_e = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (timeout) seen = 1'b1;
      else if (grant_w) g++;
    end
    chk("timeout_seen", int'(seen), 1);
    chk("grant_w_cycles", g, 8);
    chk("last_dir_after_timeout", int'(last_dir), 1);
    tick();
    chk("rr_grant_e", int'(grant_e), 1);
    chk("rr_sig_e", int'(sig_e), 3);
    chk("rr_timeout_cleared", int'(timeout), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
